fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Parametrised operand-forwarding and hazard controller for the ID stage of the pipeline. For each ID read port it selects the youngest in-flight producer (EX, MEM, WB, …) or the register file, detects load-use hazards, and tracks one outstanding multi-cycle (mult/div) write with a countdown scoreboard that stalls dependent readers and bypasses the multi-cycle result on completion. It generalises single-port jump-register forwarding to N ports, D stages, and stall generation.

## Interface
- NUM_RD, 2: ID read ports
- NUM_STG, 3: producer stages; index 0 = youngest (EX)
- AW, 5: register address width
- DW, 32: data width
- MD_LAT, 4: multi-cycle unit latency in cycles, ≥2
- SW: localparam, $clog2(NUM_STG+2), select width
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_ra  in  NUM_RD*AW  ID read addresses, port p at [p*AW +: AW]
- id_used  in  NUM_RD  port p actually consumes its operand
- rf_data  in  NUM_RD*DW  register-file read data
- stg_rw  in  NUM_STG*AW  destination per stage
- stg_regwr  in  NUM_STG  stage writes a register
- stg_load  in  NUM_STG  stage holds a load whose data is not yet in stg_result
- stg_result  in  NUM_STG*DW  result per stage
- md_start  in  1  multi-cycle op leaves EX this cycle
- md_rw  in  AW  destination of that op
- md_result  in  DW  multi-cycle result, valid while md_done
- fwd_sel  out  NUM_RD*SW  per-port source: 0 = RF, k = stage k-1, NUM_STG+1 = md_result
- fwd_data  out  NUM_RD*DW  selected operand
- stall  out  1  hold PC/IF/ID, bubble EX
- md_busy  out  1  multi-cycle op outstanding
- md_done  out  1  one-cycle completion pulse

## Operation
- Match for port p, stage s: stg_regwr[s] && stg_rw[s]==id_ra[p] && id_ra[p]!=0. Register 0 never forwards, never stalls.
- Priority: lowest matching stage index wins; no match → RF (sel 0).
- Load-use: winning stage has stg_load=1 and id_used[p]=1 → stall; fwd_sel still reports that stage.
- Scoreboard FSM, states IDLE, BUSY:
  - IDLE: md_start → BUSY, latch md_rw into pend_rw, cnt ← MD_LAT-1.
  - BUSY: cnt decrements each cycle; when cnt==0, md_done=1 and next state IDLE.
  - md_start in the md_done cycle: reload (pend_rw ← md_rw, cnt ← MD_LAT-1), stay BUSY.
  - md_start in BUSY with cnt≠0: ignored (impossible under the stall contract).
- In BUSY, port p with id_used[p] && id_ra[p]==pend_rw≠0 and cnt≠0 → stall.
- In the md_done cycle, a port matching pend_rw with no younger stage match takes md_result (sel NUM_STG+1); no stall.
- stall = OR of all load-use and scoreboard conditions across ports.

## Timing
- fwd_sel, fwd_data, stall: combinational, same cycle as inputs.
- md_busy, md_done, pend_rw, cnt: registered; md_busy=1 for MD_LAT cycles after md_start, md_done on the last.
- Reset (async assert, sync release): state IDLE, cnt 0, pend_rw 0, md_busy 0, md_done 0; combinational outputs then depend on inputs only.
- Reset mid-BUSY drops the pending op; no md_done emitted.

## Configuration
- FWD_PERF_CNT_EN defined: extra outputs stall_cnt (32b) and fwd_cnt (32b); stall_cnt increments each stall cycle, fwd_cnt each cycle any used port has fwd_sel≠0; both wrap at 2^32, reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Shared package fwd_pkg: select-code constants (FWD_RF=0, FWD_MD offset), scoreboard state enum, $clog2-based width helpers.
- One sub-module, fwd_port_sel: single-port priority match/mux, instantiated NUM_RD times by generate; scoreboard FSM and stall OR stay in the top.

## Test plan
- Port 0 ra=5, EX and WB both write r5 (0x11, 0x33) → sel 1, data 0x11; EX write cleared → sel 3, data 0x33.
- ra=0 with all stages writing r0 → sel 0, data = rf_data, stall 0.
- EX load to r7, port 1 ra=7 used → stall 1; id_used[1]=0 → stall 0; next cycle load in MEM with data 0x99 → sel 2, data 0x99, stall 0.
- md_start md_rw=9, MD_LAT=4: md_busy 4 cycles; ID reads r9 → stall in cycles 1–3, cycle 4 md_done=1, sel 4, data = md_result.
- md_start in the md_done cycle → no idle gap, md_busy high 8 consecutive cycles; rst_n low mid-BUSY → md_busy 0 immediately, no md_done.
- With FWD_PERF_CNT_EN: 3 stall cycles and 5 forwarded cycles → stall_cnt=3, fwd_cnt=5.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding/hazard unit: select codes,
// multi-cycle scoreboard state encoding and parameter-derived widths.
package fwd_pkg;

    // Select code meaning "take the register-file operand"
    localparam int FWD_RF = 0;

    typedef enum logic {
        SB_IDLE = 1'b0,
        SB_BUSY = 1'b1
    } sb_state_t;

    // Select codes: 0 = RF, 1..num_stg = stage k-1, num_stg+1 = md_result
    function automatic int sel_width(input int num_stg);
        return $clog2(num_stg + 2);
    endfunction

    function automatic int fwd_md(input int num_stg);
        return num_stg + 1;
    endfunction

    // Countdown holds MD_LAT-1 down to 0
    function automatic int cnt_width(input int md_lat);
        return (md_lat > 2) ? $clog2(md_lat) : 1;
    endfunction

endpackage

// File: rtl/fwd_port_sel.sv
// Single read-port operand selector: youngest matching producer wins,
// otherwise the completing multi-cycle result, otherwise the register file.
module fwd_port_sel
    import fwd_pkg::*;
#(
    parameter int NUM_STG = 3,
    parameter int AW      = 5,
    parameter int DW      = 32,
    parameter int SW      = sel_width(NUM_STG)
) (
    input  logic [AW-1:0]         ra,
    input  logic                  used,
    input  logic [DW-1:0]         rf_data,
    input  logic [NUM_STG*AW-1:0] stg_rw,
    input  logic [NUM_STG-1:0]    stg_regwr,
    input  logic [NUM_STG-1:0]    stg_load,
    input  logic [NUM_STG*DW-1:0] stg_result,
    input  logic                  md_done,
    input  logic [AW-1:0]         pend_rw,
    input  logic [DW-1:0]         md_result,
    output logic [SW-1:0]         sel,
    output logic [DW-1:0]         data,
    output logic                  load_stall
);

    always_comb begin
        // NOTE: every output gets a default first, so no path leaves it unassigned and no latch is inferred.
        sel        = SW'(FWD_RF);
        data       = rf_data;
        load_stall = 1'b0;

        if (ra != '0) begin
            // Lowest priority first; any pipeline-stage match overrides it below
            if (md_done && (ra == pend_rw)) begin
                sel  = SW'(fwd_md(NUM_STG));
                data = md_result;
            end

            // Walk oldest to youngest so the youngest match is assigned last and wins
            for (int s = NUM_STG - 1; s >= 0; s--) begin
                if (stg_regwr[s] && (stg_rw[s*AW +: AW] == ra)) begin
                    sel        = SW'(s + 1);
                    data       = stg_result[s*DW +: DW];
                    load_stall = used && stg_load[s];
                end
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// ID-stage operand forwarding and hazard control with a single-entry
// multi-cycle scoreboard. Optional counters enabled by FWD_PERF_CNT_EN.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter  int NUM_RD  = 2,
    parameter  int NUM_STG = 3,
    parameter  int AW      = 5,
    parameter  int DW      = 32,
    parameter  int MD_LAT  = 4,
    localparam int SW      = sel_width(NUM_STG)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_RD*AW-1:0]  id_ra,
    input  logic [NUM_RD-1:0]     id_used,
    input  logic [NUM_RD*DW-1:0]  rf_data,
    input  logic [NUM_STG*AW-1:0] stg_rw,
    input  logic [NUM_STG-1:0]    stg_regwr,
    input  logic [NUM_STG-1:0]    stg_load,
    input  logic [NUM_STG*DW-1:0] stg_result,
    input  logic                  md_start,
    input  logic [AW-1:0]         md_rw,
    input  logic [DW-1:0]         md_result,
    output logic [NUM_RD*SW-1:0]  fwd_sel,
    output logic [NUM_RD*DW-1:0]  fwd_data,
    output logic                  stall,
    output logic                  md_busy,
    output logic                  md_done
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           fwd_cnt
`endif
);

    localparam int CW = cnt_width(MD_LAT);

    sb_state_t     state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [AW-1:0] pend_rw, pend_rw_nx;
    logic [NUM_RD-1:0] load_stall;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        fwd_port_sel #(
            .NUM_STG (NUM_STG),
            .AW      (AW),
            .DW      (DW),
            .SW      (SW)
        ) u_sel (
            .ra         (id_ra[p*AW +: AW]),
            .used       (id_used[p]),
            .rf_data    (rf_data[p*DW +: DW]),
            .stg_rw     (stg_rw),
            .stg_regwr  (stg_regwr),
            .stg_load   (stg_load),
            .stg_result (stg_result),
            .md_done    (md_done),
            .pend_rw    (pend_rw),
            .md_result  (md_result),
            .sel        (fwd_sel[p*SW +: SW]),
            .data       (fwd_data[p*DW +: DW]),
            .load_stall (load_stall[p])
        );
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        pend_rw_nx = pend_rw;
        unique case (state)
            SB_IDLE: begin
                if (md_start) begin
                    state_nx   = SB_BUSY;
                    cnt_nx     = CW'(MD_LAT - 1);
                    pend_rw_nx = md_rw;
                end
            end
            SB_BUSY: begin
                if (cnt == '0) begin
                    // Completion cycle: a back-to-back op reloads without an idle gap
                    if (md_start) begin
                        cnt_nx     = CW'(MD_LAT - 1);
                        pend_rw_nx = md_rw;
                    end else begin
                        state_nx = SB_IDLE;
                    end
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            default: state_nx = SB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SB_IDLE;
            cnt     <= '0;
            pend_rw <= '0;
            md_busy <= 1'b0;
            md_done <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state   <= state_nx;
            cnt     <= cnt_nx;
            pend_rw <= pend_rw_nx;
            md_busy <= (state_nx == SB_BUSY);
            md_done <= (state_nx == SB_BUSY) && (cnt_nx == '0);
        end
    end

    always_comb begin
        stall = 1'b0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (load_stall[p]) begin
                stall = 1'b1;
            end
            // Reader of a still-running multi-cycle destination must wait
            if ((state == SB_BUSY) && (cnt != '0) && id_used[p] &&
                (pend_rw != '0) && (id_ra[p*AW +: AW] == pend_rw)) begin
                stall = 1'b1;
            end
        end
    end

`ifdef FWD_PERF_CNT_EN
    logic any_fwd;

    always_comb begin
        any_fwd = 1'b0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (id_used[p] && (fwd_sel[p*SW +: SW] != SW'(FWD_RF))) begin
                any_fwd = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (any_fwd) begin
                fwd_cnt <= fwd_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed literal cases plus
// randomized stimulus compared every cycle against a timestamp-based model.
`timescale 1ns/1ps
module tb_fwd_hazard_unit;

    localparam int NUM_RD  = 2;
    localparam int NUM_STG = 3;
    localparam int AW      = 5;
    localparam int DW      = 32;
    localparam int MD_LAT  = 4;
    localparam int SW      = $clog2(NUM_STG + 2);

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_RD*AW-1:0]  id_ra;
    logic [NUM_RD-1:0]     id_used;
    logic [NUM_RD*DW-1:0]  rf_data;
    logic [NUM_STG*AW-1:0] stg_rw;
    logic [NUM_STG-1:0]    stg_regwr;
    logic [NUM_STG-1:0]    stg_load;
    logic [NUM_STG*DW-1:0] stg_result;
    logic                  md_start;
    logic [AW-1:0]         md_rw;
    logic [DW-1:0]         md_result;
    logic [NUM_RD*SW-1:0]  fwd_sel;
    logic [NUM_RD*DW-1:0]  fwd_data;
    logic                  stall;
    logic                  md_busy;
    logic                  md_done;
`ifdef FWD_PERF_CNT_EN
    logic [31:0]           stall_cnt;
    logic [31:0]           fwd_cnt;
`endif

    fwd_hazard_unit #(
        .NUM_RD  (NUM_RD),
        .NUM_STG (NUM_STG),
        .AW      (AW),
        .DW      (DW),
        .MD_LAT  (MD_LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_ra      (id_ra),
        .id_used    (id_used),
        .rf_data    (rf_data),
        .stg_rw     (stg_rw),
        .stg_regwr  (stg_regwr),
        .stg_load   (stg_load),
        .stg_result (stg_result),
        .md_start   (md_start),
        .md_rw      (md_rw),
        .md_result  (md_result),
        .fwd_sel    (fwd_sel),
        .fwd_data   (fwd_data),
        .stall      (stall),
        .md_busy    (md_busy),
        .md_done    (md_done)
`ifdef FWD_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt),
        .fwd_cnt    (fwd_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the multi-cycle op is remembered by the cycle it left EX;
    // busy for the MD_LAT cycles after that, done on the last of them.
    int            cyc    = 0;
    bit            md_act = 1'b0;
    int            md_t0  = 0;
    logic [AW-1:0] m_pend = '0;

    function automatic bit m_busy();
        return md_act && ((cyc - md_t0) >= 1) && ((cyc - md_t0) <= MD_LAT);
    endfunction

    function automatic bit m_done();
        return md_act && ((cyc - md_t0) == MD_LAT);
    endfunction

    always @(posedge clk) begin
        if (rst_n) begin
            if (md_start && (!m_busy() || m_done())) begin
                md_act <= 1'b1;
                md_t0  <= cyc;
                m_pend <= md_rw;
            end
            cyc <= cyc + 1;
        end
    end

    always @(negedge rst_n) begin
        md_act <= 1'b0;
        m_pend <= '0;
    end

    task automatic model_port(input int p, output logic [SW-1:0] es,
                              output logic [DW-1:0] ed, output bit est);
        logic [AW-1:0] ra;
        bit hit;
        ra  = id_ra[p*AW +: AW];
        hit = 1'b0;
        es  = '0;
        ed  = rf_data[p*DW +: DW];
        est = 1'b0;
        if (ra != '0) begin
            for (int s = 0; s < NUM_STG; s++) begin
                if (!hit && stg_regwr[s] && (stg_rw[s*AW +: AW] == ra)) begin
                    hit = 1'b1;
                    es  = SW'(s + 1);
                    ed  = stg_result[s*DW +: DW];
                    est = id_used[p] && stg_load[s];
                end
            end
            if (!hit && m_done() && (ra == m_pend)) begin
                es = SW'(NUM_STG + 1);
                ed = md_result;
            end
            if (m_busy() && !m_done() && id_used[p] && (ra == m_pend)) begin
                est = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        logic [SW-1:0] es;
        logic [DW-1:0] ed;
        bit            est;
        bit            st_all;
        if (chk_en) begin
            st_all = 1'b0;
            for (int p = 0; p < NUM_RD; p++) begin
                model_port(p, es, ed, est);
                st_all = st_all | est;
                check($sformatf("m_sel%0d", p), fwd_sel[p*SW +: SW], es);
                check($sformatf("m_data%0d", p), fwd_data[p*DW +: DW], ed);
            end
            check("m_stall", stall, st_all);
            check("m_busy", md_busy, m_busy());
            check("m_done", md_done, m_done());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        id_ra      = '0;
        id_used    = '0;
        rf_data    = '0;
        stg_rw     = '0;
        stg_regwr  = '0;
        stg_load   = '0;
        stg_result = '0;
        md_start   = 1'b0;
        md_rw      = '0;
        md_result  = '0;
    endtask

    task automatic set_port(input int p, input logic [AW-1:0] ra, input logic used, input logic [DW-1:0] rf);
        id_ra[p*AW +: AW]   = ra;
        id_used[p]          = used;
        rf_data[p*DW +: DW] = rf;
    endtask

    task automatic set_stg(input int s, input logic [AW-1:0] rw, input logic wr,
                           input logic ld, input logic [DW-1:0] res);
        stg_rw[s*AW +: AW]     = rw;
        stg_regwr[s]           = wr;
        stg_load[s]            = ld;
        stg_result[s*DW +: DW] = res;
    endtask

    initial begin
        clear_inputs();
        rst_n  = 1'b0;
        chk_en = 1'b1;

        settle();
        check("rst_busy", md_busy, 0);
        check("rst_done", md_done, 0);
        check("rst_stall", stall, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Youngest producer wins, then falls back to the older one
        tick();
        set_port(0, 5, 1'b1, 32'hAAAA);
        set_stg(0, 5, 1'b1, 1'b0, 32'h11);
        set_stg(2, 5, 1'b1, 1'b0, 32'h33);
        settle();
        check("ex_sel", fwd_sel[0 +: SW], 1);
        check("ex_data", fwd_data[0 +: DW], 32'h11);
        tick();
        stg_regwr[0] = 1'b0;
        settle();
        check("wb_sel", fwd_sel[0 +: SW], 3);
        check("wb_data", fwd_data[0 +: DW], 32'h33);

        // r0 never forwards or stalls
        tick();
        clear_inputs();
        set_port(0, 0, 1'b1, 32'h1234);
        for (int s = 0; s < NUM_STG; s++) set_stg(s, 0, 1'b1, 1'b1, 32'hF0 + s);
        settle();
        check("r0_sel", fwd_sel[0 +: SW], 0);
        check("r0_data", fwd_data[0 +: DW], 32'h1234);
        check("r0_stall", stall, 0);

        // Load-use
        tick();
        clear_inputs();
        set_stg(0, 7, 1'b1, 1'b1, 32'hBAD);
        set_port(1, 7, 1'b1, 32'h5);
        settle();
        check("lu_stall", stall, 1);
        check("lu_sel", fwd_sel[SW +: SW], 1);
        tick();
        id_used[1] = 1'b0;
        settle();
        check("lu_unused_stall", stall, 0);
        tick();
        id_used[1] = 1'b1;
        set_stg(0, 0, 1'b0, 1'b0, 32'h0);
        set_stg(1, 7, 1'b1, 1'b0, 32'h99);
        settle();
        check("lu_mem_sel", fwd_sel[SW +: SW], 2);
        check("lu_mem_data", fwd_data[SW*0 + DW +: DW], 32'h99);
        check("lu_mem_stall", stall, 0);

        // Multi-cycle op to r9
        tick();
        clear_inputs();
        md_start = 1'b1;
        md_rw    = 9;
        settle();
        check("md_idle_busy", md_busy, 0);
        tick();
        md_start  = 1'b0;
        set_port(0, 9, 1'b1, 32'h0);
        md_result = 32'hDEAD;
        for (int c = 1; c <= MD_LAT; c++) begin
            settle();
            check($sformatf("md_busy_c%0d", c), md_busy, 1);
            check($sformatf("md_done_c%0d", c), md_done, (c == MD_LAT));
            check($sformatf("md_stall_c%0d", c), stall, (c < MD_LAT));
            if (c == MD_LAT) begin
                check("md_sel", fwd_sel[0 +: SW], 4);
                check("md_data", fwd_data[0 +: DW], 32'hDEAD);
            end
            tick();
        end
        settle();
        check("md_after_busy", md_busy, 0);
        check("md_after_done", md_done, 0);

        // Back-to-back ops: no idle gap
        tick();
        clear_inputs();
        md_start = 1'b1;
        md_rw    = 10;
        for (int c = 1; c <= 2 * MD_LAT; c++) begin
            tick();
            md_start = (c == MD_LAT);
            md_rw    = 11;
            settle();
            check($sformatf("b2b_busy_c%0d", c), md_busy, 1);
            check($sformatf("b2b_done_c%0d", c), md_done, (c == MD_LAT) || (c == 2 * MD_LAT));
        end
        tick();
        md_start = 1'b0;
        settle();
        check("b2b_end_busy", md_busy, 0);

        // Reset while busy drops the op
        tick();
        md_start = 1'b1;
        md_rw    = 12;
        tick();
        md_start = 1'b0;
        settle();
        check("rb_busy", md_busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rb_busy_drop", md_busy, 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < MD_LAT + 1; c++) begin
            settle();
            check("rb_no_done", md_done, 0);
            tick();
        end

`ifdef FWD_PERF_CNT_EN
        rst_n = 1'b0;
        #2;
        check("pc_rst_stall", stall_cnt, 0);
        check("pc_rst_fwd", fwd_cnt, 0);
        tick();
        rst_n = 1'b1;
        clear_inputs();
        md_start = 1'b1;
        md_rw    = 13;
        for (int c = 1; c < MD_LAT; c++) begin
            tick();
            md_start = 1'b0;
            set_port(0, 13, 1'b1, 32'h0);
        end
        tick();
        clear_inputs();
        for (int c = 0; c < 5; c++) begin
            tick();
            set_stg(0, 3, 1'b1, 1'b0, 32'h77);
            set_port(0, 3, 1'b1, 32'h0);
        end
        tick();
        clear_inputs();
        settle();
        check("pc_stall_cnt", stall_cnt, 3);
        check("pc_fwd_cnt", fwd_cnt, 5);
`endif

        // Randomized phase, one mid-run reset pulse
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (i == 1500) rst_n = 1'b0;
            if (i == 1503) rst_n = 1'b1;
            for (int p = 0; p < NUM_RD; p++) begin
                set_port(p, AW'($urandom_range(0, 7)), 1'($urandom), $urandom);
            end
            for (int s = 0; s < NUM_STG; s++) begin
                set_stg(s, AW'($urandom_range(0, 7)), 1'($urandom), ($urandom_range(0, 3) == 0), $urandom);
            end
            md_start  = ($urandom_range(0, 5) == 0);
            md_rw     = AW'($urandom_range(0, 7));
            md_result = $urandom;
            settle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
